instr_fetch_stage: RTL and testbench
====================================

# instr_fetch_stage

Instruction-fetch stage of the MIPS datapath. Owns the program-counter register, issues word fetches to instruction memory over a req/ack handshake, and presents each fetched instruction with its PC to decode over a valid/ready handshake. Sits directly upstream of the next-PC logic: `pc` feeds that logic's current-address input, and its chosen address returns on `next_pc`.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be word-aligned.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `next_pc` in 32: address chosen by the next-PC logic (PC+4 / branch / jump); sampled only on a decode handshake.
- `flush` in 1: redirect request; overrides every other event in the same cycle.
- `flush_pc` in 32: redirect target, sampled when `flush`=1.
- `pc` out 32: current PC register.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address, stable while `imem_req`=1.
- `imem_ack` in 1: one-cycle acknowledge; `imem_rdata` valid in the same cycle.
- `imem_rdata` in 32: fetched word.
- `out_valid` out 1: instruction available to decode.
- `out_ready` in 1: decode accepts.
- `out_instr` out 32: fetched instruction.
- `out_pc` out 32: address of `out_instr`.
- `misaligned` out 1: sticky flag; a loaded PC had bits [1:0] != 0.

## Operation
- States: IDLE, FETCH, HOLD, DRAIN. `imem_req`=1 in FETCH and DRAIN only. `out_valid`=1 in HOLD only.
- Reset (async): state=IDLE, `pc`=`RESET_PC`, `imem_addr`=`RESET_PC`, `out_valid`=0, `out_instr`=0, `out_pc`=0, `misaligned`=0.
- IDLE: next edge goes to FETCH with `imem_addr`<=`pc`. If `flush`=1: `pc`<=`flush_pc`, `imem_addr`<=`flush_pc`.
- FETCH, `imem_ack`=1, `flush`=0: `out_instr`<=`imem_rdata`, `out_pc`<=`imem_addr`, go to HOLD.
- FETCH, `flush`=1, `imem_ack`=1: discard data, `pc`/`imem_addr`<=`flush_pc`, stay in FETCH.
- FETCH, `flush`=1, `imem_ack`=0: `pc`<=`flush_pc`; `imem_addr` unchanged; go to DRAIN.
- DRAIN: hold the old request until `imem_ack`. On ack, discard data, set `imem_addr`<=`pc`, go to FETCH. A further `flush` in DRAIN updates `pc` to the newest `flush_pc`. A flush coinciding with the ack uses the new `flush_pc`.
- HOLD, `flush`=1: drop the instruction (`out_valid`<=0), `pc`/`imem_addr`<=`flush_pc`, go to FETCH. Flush wins over `out_ready`.
- HOLD, `out_ready`=1, `flush`=0: handshake completes; `pc`/`imem_addr`<=`next_pc`, go to FETCH.
- HOLD, `out_ready`=0: all outputs held stable.
- PC loads from `next_pc` or `flush_pc`:
  - Bits [1:0] are forced to 00 before storing.
  - If the raw bits were nonzero, set `misaligned`. It clears only on `rst`.
- `imem_ack` outside FETCH/DRAIN is ignored.
- No wrap checks: 32-bit PC arithmetic happens upstream; 32'hFFFF_FFFC is a legal PC.

## Timing
- Fetch may complete in the first FETCH cycle (zero-wait memory).
- `out_valid` rises one cycle after the accepting `imem_ack`.
- Best-case throughput: one instruction per 2 cycles (FETCH, HOLD), with zero-wait memory and `out_ready` held at 1.
- After `rst` deasserts: IDLE for 1 cycle, then `imem_req`=1 with `imem_addr`=`RESET_PC`.
- `imem_addr` never changes while `imem_req`=1 and no ack has arrived.
- Flush in HOLD: new request issued the next cycle.
- Flush in FETCH without ack: new request issued the cycle after the old one's ack.
- All outputs are registered or decoded from state. No combinational path from `out_ready` or `imem_ack` to outputs.

## Test plan
- Reset, zero-wait memory, `out_ready`=1, `RESET_PC`=0, memory word n = n:
  - Expect addresses 0,4,8 issued on alternate cycles.
  - Expect `out_instr`/`out_pc` = (0,0),(4,4),(8,8) with `next_pc`=`pc`+4.
- Backpressure: `out_ready`=0 for 5 cycles in HOLD.
  - `out_valid`, `out_instr` and `out_pc` stay stable.
  - No `imem_req`.
  - `pc` advances only after `out_ready`=1.
- Flush with a request outstanding: memory latency 3, `flush_pc`=0x100 one cycle into a fetch of 0x8.
  - `imem_addr` stays 0x8 until ack.
  - Data is discarded and `out_valid` stays 0.
  - The next request is 0x100.
- Flush in HOLD together with `out_ready`=1, `next_pc`=0x20, `flush_pc`=0x40.
  - Instruction is not delivered.
  - Next fetch address is 0x40.
- `next_pc`=0x0000_0206:
  - `pc` becomes 0x204 and `misaligned`=1.
  - Flag stays set through later aligned fetches.
  - Flag clears on `rst`.
- Assert `rst` while in DRAIN:
  - Outputs return to reset values immediately (asynchronously).
  - After release, the first request is `RESET_PC`.

Source files
------------

// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage
// Instruction-fetch stage: owns the PC, fetches one word at a time from
// instruction memory (req/ack) and hands each instruction plus its address
// to decode (valid/ready). A flush redirects the PC and abandons any
// in-flight work; an outstanding memory request is always allowed to
// complete (DRAIN) before the redirected fetch is issued.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   next_pc             next address from next-PC logic, taken on decode handshake
//   flush, flush_pc     redirect request / target (flush overrides everything)
//   pc                  current PC register
//   imem_req/addr       fetch request and address (address stable while pending)
//   imem_ack/rdata      one-cycle acknowledge with read data
//   out_valid/ready     instruction handshake towards decode
//   out_instr, out_pc   delivered instruction and its address
//   misaligned          sticky: some loaded PC had nonzero bits [1:0]
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_pc,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        misaligned
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

  state_t      state, state_nx;
  logic [31:0] pc_nx, addr_nx, instr_nx, opc_nx;
  logic        mis_nx;
  logic        load_en;
  logic [31:0] load_raw;
  logic [31:0] load_al;

  // Every PC load goes through one path so alignment and the sticky flag
  // are handled identically for flush and next_pc sources.
  assign load_al = {load_raw[31:2], 2'b00};

  always_comb begin
    state_nx = state;
    addr_nx  = imem_addr;
    instr_nx = out_instr;
    opc_nx   = out_pc;
    load_en  = 1'b0;
    load_raw = flush_pc;
    case (state)
      IDLE: begin
        state_nx = FETCH;
        addr_nx  = pc;
        if (flush) begin
          load_en = 1'b1;
          addr_nx = load_al;
        end
      end
      FETCH: begin
        if (flush) begin
          load_en = 1'b1;
          if (imem_ack) addr_nx = load_al;
          else          state_nx = DRAIN;
        end else if (imem_ack) begin
          instr_nx = imem_rdata;
          opc_nx   = imem_addr;
          state_nx = HOLD;
        end
      end
      DRAIN: begin
        // The old request stays on the bus; only pc tracks the newest redirect.
        if (flush) load_en = 1'b1;
        if (imem_ack) begin
          addr_nx  = flush ? load_al : pc;
          state_nx = FETCH;
        end
      end
      HOLD: begin
        if (flush) begin
          load_en  = 1'b1;
          addr_nx  = load_al;
          state_nx = FETCH;
        end else if (out_ready) begin
          load_en  = 1'b1;
          load_raw = next_pc;
          addr_nx  = load_al;
          state_nx = FETCH;
        end
      end
      default: state_nx = IDLE;
    endcase
    pc_nx  = load_en ? load_al : pc;
    mis_nx = misaligned | (load_en & (|load_raw[1:0]));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      imem_addr  <= RESET_PC;
      out_instr  <= '0;
      out_pc     <= '0;
      misaligned <= 1'b0;
    end else begin
      state      <= state_nx;
      pc         <= pc_nx;
      imem_addr  <= addr_nx;
      out_instr  <= instr_nx;
      out_pc     <= opc_nx;
      misaligned <= mis_nx;
    end
  end

  assign imem_req  = (state == FETCH) || (state == DRAIN);
  assign out_valid = (state == HOLD);

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage. A driver issues random
// decode/flush stimulus and pushes the address of the next instruction that
// must reach decode into a scoreboard queue; a memory responder serves
// fetches with random latency; a monitor pops and compares on every
// delivered instruction.
module tb_instr_fetch_stage;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] next_pc, flush_pc, pc, imem_addr, imem_rdata, out_instr, out_pc;
  logic        flush, imem_req, imem_ack, out_valid, out_ready, misaligned;

  always #5 clk = ~clk;

  instr_fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .next_pc(next_pc), .flush(flush), .flush_pc(flush_pc),
    .pc(pc), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .misaligned(misaligned)
  );

  int unsigned checks = 0;
  int unsigned fails  = 0;

  // reference model state
  logic [31:0] exp_q[$];
  logic [31:0] pc_model, pc_next;
  logic        mis_model, mis_next;

  // stimulus knobs
  int unsigned p_ready = 100, p_flush = 0, p_jump = 0, lat_max = 3;
  int          lat_fix = 0;
  bit          spur_en = 1'b0;
  bit          force_flush = 1'b0, force_ready = 1'b0, force_np_en = 1'b0;
  logic [31:0] force_fpc, force_np;

  int unsigned cyc = 0;
  int unsigned deliveries = 0;
  int unsigned dcyc[3];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    fails++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Driver: inputs for the coming edge, plus the model's view of that edge.
  initial begin
    flush = 1'b0; flush_pc = '0; next_pc = '0; out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        flush = 1'b0;
        out_ready = 1'b0;
      end else begin
        mis_model = mis_next;
        pc_model  = pc_next;
        out_ready = force_ready || ($urandom_range(99) < p_ready);
        force_ready = 1'b0;
        flush = force_flush || (p_flush != 0 && $urandom_range(99) < p_flush);
        flush_pc = force_flush ? force_fpc : {20'h0, 10'($urandom), 2'b00};
        force_flush = 1'b0;
        if (force_np_en)
          next_pc = force_np;
        else if (p_jump != 0 && $urandom_range(99) < p_jump)
          next_pc = {16'h0, 14'($urandom), 2'b00};
        else
          next_pc = out_pc + 32'd4;
        if (flush) begin
          exp_q.delete();
          exp_q.push_back(align(flush_pc));
          pc_next  = align(flush_pc);
          mis_next = mis_next | (flush_pc[1:0] != 2'b00);
        end else if (out_valid && out_ready) begin
          exp_q.push_back(align(next_pc));
          pc_next  = align(next_pc);
          mis_next = mis_next | (next_pc[1:0] != 2'b00);
          force_np_en = 1'b0;
        end
      end
    end
  end

  // Memory responder with per-request latency; also injects stray acks.
  int          rcnt, rlat;
  bit          pend = 1'b0;
  logic [31:0] raddr;
  initial begin
    imem_ack = 1'b0; imem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        imem_ack = 1'b0;
        pend = 1'b0;
      end else if (imem_req) begin
        if (!pend) begin
          pend = 1'b1;
          rcnt = 0;
          rlat = (lat_fix >= 0) ? lat_fix : int'($urandom_range(lat_max));
          raddr = imem_addr;
        end else begin
          chk("imem_addr_stable", imem_addr, raddr);
        end
        if (rcnt == rlat) begin
          imem_ack = 1'b1;
          imem_rdata = mem_word(imem_addr);
          pend = 1'b0;
        end else begin
          imem_ack = 1'b0;
          imem_rdata = $urandom;
          rcnt++;
        end
      end else begin
        pend = 1'b0;
        imem_ack = spur_en && ($urandom_range(3) == 0);
        imem_rdata = $urandom;
      end
    end
  end

  // Monitor
  bit          hold_prev = 1'b0;
  logic [31:0] hv_i, hv_p, e;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      chk("pc", pc, pc_model);
      chk("misaligned", 32'(misaligned), 32'(mis_model));
      chk("req_and_valid", 32'(out_valid & imem_req), 32'd0);
      if (hold_prev) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_instr", out_instr, hv_i);
        chk("hold_pc", out_pc, hv_p);
      end
      if (out_valid && out_ready && !flush) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL deliver: got pc %h expected no delivery", out_pc);
        end else begin
          e = exp_q.pop_front();
          chk("out_pc", out_pc, e);
          chk("out_instr", out_instr, mem_word(e));
          if (deliveries < 3) dcyc[deliveries] = cyc;
          deliveries++;
        end
      end
      hold_prev = out_valid && !out_ready && !flush;
      hv_i = out_instr;
      hv_p = out_pc;
    end
  end

  task automatic reset_checks();
    chk("rst_pc", pc, RST_PC);
    chk("rst_imem_addr", imem_addr, RST_PC);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_misaligned", 32'(misaligned), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    reset_checks();
    repeat (2) @(posedge clk);
    exp_q.delete();
    exp_q.push_back(RST_PC);
    pc_model = RST_PC; pc_next = RST_PC;
    mis_model = 1'b0; mis_next = 1'b0;
    force_flush = 1'b0; force_ready = 1'b0; force_np_en = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("idle_no_req", 32'(imem_req), 32'd0);
    @(posedge clk); #2;
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, RST_PC);
  endtask

  task automatic wait_deliv(input int unsigned n, input int unsigned budget, input string name);
    int unsigned start;
    bit got;
    start = deliveries;
    got = 1'b0;
    for (int i = 0; i < int'(budget) && !got; i++) begin
      @(posedge clk);
      got = (deliveries >= start + n);
    end
    if (!got) timeout(name);
  endtask

  task automatic wait_valid(input int unsigned budget, input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < int'(budget) && !got; i++) begin
      @(negedge clk);
      got = out_valid;
    end
    if (!got) timeout(name);
  endtask

  task automatic wait_req_rise(input int unsigned budget, input string name);
    bit got, prev;
    got = 1'b0;
    prev = 1'b1;
    for (int i = 0; i < int'(budget) && !got; i++) begin
      @(negedge clk);
      got = imem_req && !prev;
      prev = imem_req;
    end
    if (!got) timeout(name);
  endtask

  logic [31:0]  pc_snap;
  int unsigned  d_before;

  initial begin
    #2;
    do_reset();

    // zero-wait memory, always ready: one instruction every 2 cycles
    wait_deliv(3, 50, "stream");
    chk("throughput_1", dcyc[1] - dcyc[0], 32'd2);
    chk("throughput_2", dcyc[2] - dcyc[1], 32'd2);

    // backpressure in HOLD
    p_ready = 0;
    wait_valid(20, "bp_valid");
    pc_snap = pc;
    repeat (5) @(negedge clk);
    chk("bp_pc_held", pc, pc_snap);
    p_ready = 100;
    wait_deliv(2, 50, "bp_release");

    // flush while a slow fetch is outstanding
    lat_fix = 3;
    wait_req_rise(30, "slow_req");
    force_fpc = 32'h100;
    force_flush = 1'b1;
    wait_deliv(2, 80, "drain_flush");

    // flush and ready together in HOLD: flush wins
    lat_fix = 0;
    p_ready = 0;
    wait_valid(30, "hold_valid_wait");
    force_fpc = 32'h40;
    force_np = 32'h20;
    force_np_en = 1'b1;
    force_ready = 1'b1;
    force_flush = 1'b1;
    @(posedge clk);
    p_ready = 100;
    wait_deliv(2, 50, "hold_flush");

    // misaligned next_pc
    lat_fix = -1;
    force_np = 32'h0000_0206;
    force_np_en = 1'b1;
    wait_deliv(3, 100, "misaligned_seq");

    // random traffic
    p_ready = 70; p_flush = 5; p_jump = 20; spur_en = 1'b1;
    d_before = deliveries;
    repeat (3000) @(posedge clk);
    checks++;
    if (deliveries - d_before < 100) begin
      fails++;
      $display("FAIL random_progress: got %0d deliveries expected at least 100", deliveries - d_before);
    end

    // asynchronous reset while draining
    p_flush = 0; p_ready = 100; p_jump = 0; spur_en = 1'b0; lat_fix = 3;
    wait_req_rise(40, "drain_req");
    force_fpc = 32'h80;
    force_flush = 1'b1;
    @(posedge clk);
    @(posedge clk); #3;
    chk("drain_req_held", 32'(imem_req), 32'd1);
    chk("mis_before_rst", 32'(misaligned), 32'd1);
    do_reset();
    lat_fix = -1;
    wait_deliv(3, 100, "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
